// File: rtl/softmax_stream.sv
// Length-masked, numerically stable softmax over one vector of NUM signed scores.
// Sequence per vector: running max, shift-and-add exp2 approximation, serial restoring divide.
module softmax_stream #(
  parameter int D_W   = 16,
  parameter int FRAC  = 12,
  parameter int NUM   = 16,
  parameter int LEN_W = $clog2(NUM + 1)
) (
  input  logic               I_CLK,
  input  logic               I_RST_N,
  input  logic               I_VLD,
  output logic               O_RDY,
  input  logic [D_W*NUM-1:0] I_DATA,
  input  logic [LEN_W-1:0]   I_LEN,
  output logic               O_VLD,
  input  logic               I_RDY,
  output logic [D_W*NUM-1:0] O_DATA
);

  localparam int SW    = D_W + LEN_W;
  localparam int T_W   = D_W + 3;
  localparam int ST_W  = $clog2(FRAC + 2);
  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic [2:0] {IDLE, MAX, EXP, DIV, OUT} state_t;

  state_t                  state;
  logic                    o_rdy_r;
  logic                    o_vld_r;
  logic [D_W*NUM-1:0]      o_data_r;
  logic signed [D_W-1:0]   x_buf [NUM];
  logic [D_W-1:0]          e_buf [NUM];
  logic [LEN_W-1:0]        len_r;
  logic [LEN_W-1:0]        idx;
  logic signed [D_W-1:0]   max_r;
  logic [SW-1:0]           sum_r;
  logic [SW-1:0]           rem_r;
  logic [FRAC:0]           q_r;
  logic [ST_W-1:0]         step;

  logic [LEN_W-1:0]        len_in;
  logic [IDX_W-1:0]        idx_i;
  logic                    idx_last;
  logic signed [D_W-1:0]   x_cur;
  logic signed [D_W:0]     d;
  logic signed [T_W-1:0]   dx;
  logic signed [T_W-1:0]   t;
  logic signed [T_W-1:0]   n;
  logic [T_W-1:0]          neg_n;
  logic [D_W:0]            mant;
  logic [D_W-1:0]          e_val;
  logic [SW:0]             trial;
  logic                    q_bit;
  logic [SW-1:0]           rem_nxt;
  logic [FRAC:0]           q_nxt;

  assign O_RDY  = o_rdy_r;
  assign O_VLD  = o_vld_r;
  assign O_DATA = o_data_r;

  // exp(d) is evaluated as 2^(d*log2e); 1 + 1/2 - 1/16 approximates log2(e)
  always_comb begin
    len_in   = (I_LEN > LEN_W'(NUM)) ? LEN_W'(NUM) : I_LEN;
    idx_i    = idx[IDX_W-1:0];
    idx_last = (idx + LEN_W'(1)) == len_r;
    x_cur    = x_buf[idx_i];
    d        = {x_cur[D_W-1], x_cur} - {max_r[D_W-1], max_r};
    dx       = {{2{d[D_W]}}, d};
    t        = dx + (dx >>> 1) - (dx >>> 4);
    n        = t >>> FRAC;
    neg_n    = -n;
    mant     = {{(D_W - FRAC){1'b0}}, 1'b1, t[FRAC-1:0]};
    e_val    = '0;
    if (neg_n < T_W'(D_W))
      e_val = D_W'(mant >> neg_n);
  end

  // Remainder always stays below sum, so one extra bit covers the doubled trial value
  always_comb begin
    trial   = (step == '0) ? {{(SW + 1 - D_W){1'b0}}, e_buf[idx_i]} : {rem_r, 1'b0};
    q_bit   = trial >= {1'b0, sum_r};
    rem_nxt = q_bit ? SW'(trial - {1'b0, sum_r}) : trial[SW-1:0];
    q_nxt   = {q_r[FRAC-1:0], q_bit};
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state    <= IDLE;
      o_rdy_r  <= 1'b1;
      o_vld_r  <= 1'b0;
      o_data_r <= '0;
      len_r    <= '0;
      idx      <= '0;
      max_r    <= '0;
      sum_r    <= '0;
      rem_r    <= '0;
      q_r      <= '0;
      step     <= '0;
      for (int k = 0; k < NUM; k++) begin
        x_buf[k] <= '0;
        e_buf[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (I_VLD && o_rdy_r) begin
            o_rdy_r <= 1'b0;
            for (int k = 0; k < NUM; k++)
              x_buf[k] <= I_DATA[D_W*k +: D_W];
            len_r <= len_in;
            idx   <= '0;
            max_r <= '0;
            sum_r <= '0;
            rem_r <= '0;
            q_r   <= '0;
            step  <= '0;
            state <= (len_in == '0) ? DIV : MAX;
          end
        end
        MAX: begin
          if (idx == '0 || x_cur > max_r)
            max_r <= x_cur;
          if (idx_last) begin
            idx   <= '0;
            state <= EXP;
          end else begin
            idx <= idx + LEN_W'(1);
          end
        end
        EXP: begin
          e_buf[idx_i] <= e_val;
          sum_r        <= sum_r + SW'(e_val);
          if (idx_last) begin
            idx   <= '0;
            step  <= '0;
            state <= DIV;
          end else begin
            idx <= idx + LEN_W'(1);
          end
        end
        DIV: begin
          if (idx == len_r) begin
            for (int k = 0; k < NUM; k++)
              if (LEN_W'(k) >= len_r)
                o_data_r[D_W*k +: D_W] <= '0;
            o_vld_r <= 1'b1;
            state   <= OUT;
          end else if (step == ST_W'(FRAC)) begin
            o_data_r[D_W*idx_i +: D_W] <= D_W'(q_nxt);
            idx  <= idx + LEN_W'(1);
            step <= '0;
            rem_r <= '0;
            q_r  <= '0;
          end else begin
            step  <= step + ST_W'(1);
            rem_r <= rem_nxt;
            q_r   <= q_nxt;
          end
        end
        OUT: begin
          if (I_RDY) begin
            o_vld_r <= 1'b0;
            o_rdy_r <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/softmax_stream.md
Name: softmax_stream

Overview:
- Numerically stable, length-masked softmax over one vector of NUM signed fixed-point scores.
- Computes out_i = exp(x_i - max) / sum_j exp(x_j - max) for the first I_LEN elements; masked elements output 0.
- Input side uses a valid/ready handshake; output side holds its result under backpressure.
- Sits between the QK^T score stage and the score x V stage of the attention datapath.

Parameters:
- D_W, 16: element width. Input is signed with FRAC fraction bits; output is unsigned with FRAC fraction bits.
- FRAC, 12: fraction bits; 1.0 = 2^FRAC. Constraint: FRAC+1 <= D_W.
- NUM, 16: elements per vector.
- LEN_W, $clog2(NUM+1): width of I_LEN.

Ports:
- I_CLK  in  1  clock
- I_RST_N  in  1  asynchronous active-low reset
- I_VLD  in  1  input vector valid
- O_RDY  out  1  block can accept a vector
- I_DATA  in  D_W*NUM  scores; element i is [D_W*i +: D_W]
- I_LEN  in  LEN_W  active element count; elements >= I_LEN are masked
- O_VLD  out  1  result valid; held until taken
- I_RDY  in  1  downstream ready
- O_DATA  out  D_W*NUM  probabilities, same packing as I_DATA

Behaviour:
- One clock I_CLK; reset asynchronous active-low on I_RST_N.
- Reset values: O_RDY=1, O_VLD=0, O_DATA=0. State=IDLE; all counters, max, sum and buffers cleared.
- Reset mid-operation aborts the vector immediately; no partial output is produced.
- Accept: I_VLD & O_RDY at a rising edge.
  - I_DATA and I_LEN are captured into internal registers; inputs are don't-care afterwards.
  - O_RDY falls on the same edge and stays low until the result is taken.
- LEN = min(I_LEN, NUM).
  - LEN=0: go to OUT on the next edge with O_DATA all zero.
- States: IDLE -> MAX -> EXP -> DIV -> OUT -> IDLE.
- MAX: one element per cycle, LEN cycles; running signed max of elements 0..LEN-1.
- EXP: one element per cycle, LEN cycles.
  - d = x_i - max (signed D_W+1 bits, always <= 0).
  - t = d + (d>>>1) - (d>>>4), an approximation of d*log2(e).
  - n = t>>>FRAC (floor); f = t[FRAC-1:0].
  - e_i = ((1<<FRAC) + f) >> (-n); e_i = 0 if -n >= D_W.
  - Store e_i in an internal buffer. Accumulate sum in a D_W+LEN_W-bit unsigned register, no overflow possible.
  - The max element gives e = 1.0, so sum >= 1.0 and divide-by-zero cannot occur.
- DIV: serial restoring divider, q_i = floor(e_i * 2^FRAC / sum).
  - One quotient bit per cycle: FRAC+1 cycles per element, LEN elements in order.
  - e_i <= sum guarantees q_i <= 2^FRAC, so the result fits without saturation.
  - q_i is written to O_DATA element i; elements >= LEN are written 0.
- Latency: O_VLD rises exactly 2*LEN + LEN*(FRAC+1) + 1 cycles after the accept edge.
- OUT: O_VLD=1 and O_DATA stable while I_RDY=0.
  - On the edge where O_VLD & I_RDY: O_VLD->0, O_RDY->1, state->IDLE. O_DATA keeps its value until the next result is written.
  - A new vector can be accepted on the cycle after the handshake, not in the same cycle.
- I_VLD while busy is ignored; there is no queueing.
- Element order and packing are preserved; no rounding beyond what is specified.
- Implementation target: 200-350 lines.

Test Plan (D_W=16, FRAC=12, NUM=4 unless noted):
- All four scores 0, LEN=4 -> each e=4096, sum=16384, O_DATA = {1024,1024,1024,1024}; O_VLD exactly 61 cycles after accept.
- Scores {0x1000 (1.0), 0x8000, 0x8000, 0x8000}, LEN=4 -> for the others d=-9.0, t=-12.9375, n=-13, e=4352>>13=0; O_DATA = {4096,0,0,0}.
- Scores {0,0,0x7FFF,0x7FFF}, LEN=2 -> O_DATA = {2048,2048,0,0}; masked large values ignored for max; O_VLD after 31 cycles.
- Case 1 with I_RDY held low 10 cycles after O_VLD -> O_VLD and O_DATA stable, O_RDY=0, extra I_VLD pulses ignored; handshake then releases O_RDY next edge.
- Assert I_RST_N low for 1 cycle during DIV -> O_VLD=0, O_DATA=0, O_RDY=1 immediately; the next vector, case 2, completes correctly.
- I_LEN=0, then I_LEN=7 (clamped to 4) with case 1 data -> all-zero result after 1 cycle; then {1024 x4} after 61 cycles.
